simon_round_seq: RTL
====================

Name: simon_round_seq

Overview:
- Iterative Simon64/128 encryption engine. Reuses the existing single-round datapath (n=32) once per clock for ROUNDS cycles.
- Generates round keys on the fly from a 128-bit master key.
- Valid/ready handshakes on the input and output sides.
- Sits between the block-cipher front end (plaintext/key source) and the result sink; it is the sequencer that owns the round datapath.

Parameters:
- ROUNDS, 44, number of rounds applied; legal 1..62. 44 is Simon64/128 standard.
- CNT_W, 6, width of the round counter; must satisfy 2**CNT_W > ROUNDS.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext+key offered
- in_ready  out  1  engine can accept (high only in IDLE)
- in_block  in  64  plaintext; [63:32] = left word x1, [31:0] = right word x0
- in_key  in  128  master key; [31:0]=k0, [63:32]=k1, [95:64]=k2, [127:96]=k3
- out_valid  out  1  ciphertext available
- out_ready  in  1  sink accepts ciphertext
- out_block  out  64  ciphertext, same word layout as in_block
- busy  out  1  high in RUN or DONE
- round_idx  out  CNT_W  index of round applied on next edge in RUN; 0 otherwise

Behaviour:
- Reset (async, any state, including mid-run):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; round_idx=0.
  - Block register and key window cleared to 0; out_block=0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready edge:
    - block reg <= in_block; key window {w3,w2,w1,w0} <= {k3,k2,k1,k0}.
    - Counter <= 0; go to RUN.
  - RUN: each edge:
    - block reg <= round(block reg, w0).
    - Key window shifts: w0<=w1, w1<=w2, w2<=w3, w3<=knew.
    - Counter++.
    - On the edge where counter==ROUNDS-1: go to DONE, out_valid<=1.
  - DONE: out_valid=1; out_block = block reg, held stable until out_ready. On out_valid&out_ready edge: out_valid<=0, go to IDLE.
- Latency:
  - out_valid rises exactly ROUNDS edges after the accept edge.
  - Minimum accept-to-accept interval is ROUNDS+2 cycles: no overlap, in_ready=0 in DONE even if out_ready=1.
- Round function (existing datapath):
  - y[63:32] = (rol1(x1)&rol8(x1)) ^ rol2(x1) ^ x0 ^ k.
  - y[31:0] = x1.
- Key schedule (m=4), at round index i:
  - t = ror3(w3) ^ w1; t = t ^ ror1(t).
  - knew = ~w0 ^ t ^ z3[i mod 62] ^ 32'h3, where z3 bit is zero-extended into bit 0.
  - All arithmetic is 32-bit XOR/rotate only; no carries.
- z3 sequence, bit i read left to right: 11011011101011000110010111100000010010001010011100110100001111.
- Ignored events:
  - in_valid while not IDLE: no effect.
  - out_ready while not DONE: no effect.
- round_idx = counter value in RUN.

Decomposition:
- Package simon_pkg:
  - WORD_W=32, BLOCK_W=64, KEY_W=128, KEY_WORDS=4.
  - Z3 62-bit constant, ROUND_CONST=32'hFFFFFFFC (equivalently ~w0 ^ 3).
  - State enum {IDLE,RUN,DONE}.
  - Rotate helper functions.
- Sub-module: instantiate existing round_llm as the combinational round datapath (x=block reg, k=w0). Key-schedule step stays inline.

Test Plan:
- Standard vector: in_block=64'h656b696c_20646e75, in_key=128'h1b1a1918_13121110_0b0a0908_03020100, out_ready=1 -> out_valid 44 edges after accept, out_block=64'h44c8fc20_b9dfa07a, busy high 45 cycles.
- Back-pressure: same vector, out_ready=0 for 10 cycles after out_valid -> out_valid and out_block stable all 10 cycles, in_ready=0 throughout; IDLE one edge after out_ready=1.
- Busy ignore: second in_valid with different data held during RUN and DONE -> not accepted; first result unchanged; second accepted only after return to IDLE, yields its own correct ciphertext.
- Reset mid-run: assert rst at round_idx=20 -> out_valid=0, in_ready=1, busy=0, out_block=0 immediately; rerun standard vector -> 64'h44c8fc20_b9dfa07a.
- ROUNDS=1 build: in_block=64'h00000001_00000000, in_key=0 -> out_valid one edge after accept, out_block=64'h00000004_00000001.
- Back-to-back: two vectors with in_valid held high and out_ready=1 -> accept edges exactly ROUNDS+2 cycles apart, both results correct.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared widths, payload structs, constants and rotate helpers for the Simon64/128 engine.
package simon_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLOCK_W   = 64;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned KEY_WORDS = 4;
  localparam int unsigned Z3_LEN    = 62;
  localparam int unsigned Z3_IDX_W  = 6;

  // z3 sequence; sequence bit i sits at Z3[Z3_LEN-1-i] (leftmost digit is bit 0).
  localparam logic [Z3_LEN-1:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;

  // ~w0 ^ 3 folded into a single XOR constant.
  localparam logic [WORD_W-1:0] ROUND_CONST = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [WORD_W-1:0] word_t;

  // Block payload: x1 is the left (upper) word.
  typedef struct packed {
    word_t x1;
    word_t x0;
  } block_t;

  // Sliding key window: w0 is the key consumed by the current round.
  typedef struct packed {
    word_t w3;
    word_t w2;
    word_t w1;
    word_t w0;
  } key_t;

  // Rotate left by a constant amount (1..WORD_W-1).
  function automatic word_t rol(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  // Rotate right by a constant amount (1..WORD_W-1).
  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // z3 bit for round index i, wrapping every 62 rounds.
  function automatic logic z3_bit(input int unsigned i);
    logic [Z3_IDX_W-1:0] idx;
    idx = Z3_IDX_W'(Z3_LEN - 1 - (i % Z3_LEN));
    return Z3[idx];
  endfunction

endpackage

// File: rtl/round_llm.sv
// Combinational single Simon round (n=32): y = {f(x1) ^ x0 ^ k, x1}.
module round_llm
  import simon_pkg::*;
(
  input  logic [BLOCK_W-1:0] x_i,
  input  logic [WORD_W-1:0]  k_i,
  output logic [BLOCK_W-1:0] y_o_c
);

  word_t x1;
  word_t x0;
  word_t f;

  // Feistel round: mix the left word, swap halves.
  always_comb begin
    x1    = x_i[BLOCK_W-1:WORD_W];
    x0    = x_i[WORD_W-1:0];
    f     = (rol(x1, 1) & rol(x1, 8)) ^ rol(x1, 2);
    y_o_c = {f ^ x0 ^ k_i, x1};
  end

endmodule

// File: rtl/simon_round_seq.sv
// Iterative Simon64/128 encryptor: one round per clock with on-the-fly key schedule.
module simon_round_seq
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS = 44,
  parameter int unsigned CNT_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy,
  output logic [CNT_W-1:0]   round_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  state_e             state_q;
  block_t             block_q;
  block_t             block_d;
  key_t               key_q;
  key_t               key_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [BLOCK_W-1:0] round_y;
  word_t              t0;
  word_t              t1;
  word_t              knew;
  logic               z_bit;

  // Round datapath operates on the block register with the window's oldest key word.
  round_llm u_round (
    .x_i   (block_q),
    .k_i   (key_q.w0),
    .y_o_c (round_y)
  );

  // Next block value and next key-window contents for the current round.
  always_comb begin
    block_d = block_t'(round_y);
    z_bit   = z3_bit(32'(cnt_q));
    t0      = ror(key_q.w3, 3) ^ key_q.w1;
    t1      = t0 ^ ror(t0, 1);
    knew    = key_q.w0 ^ ROUND_CONST ^ t1 ^ {{(WORD_W-1){1'b0}}, z_bit};
    key_d   = '{w3: knew, w2: key_q.w3, w1: key_q.w2, w0: key_q.w1};
  end

  // Sequencer: accept in IDLE, iterate ROUNDS times in RUN, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      block_q     <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            block_q    <= block_t'(in_block);
            key_q      <= key_t'(in_key);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          block_q <= block_d;
          key_q   <= key_d;
          if (cnt_q == LAST_IDX) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_block = block_q;
  assign round_idx = cnt_q;

endmodule
